// File: rtl/ex_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_pkg
//   Shared types for the execute operand stage.
//   - alu_op_e : 3-bit ALU opcode carried from decode into execute.
//   - fwd_sel_e: operand source selected by the forwarding logic.
// ---------------------------------------------------------------------------
package ex_operand_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_PASSB = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // use the value read from the register file
    FWD_WB  = 2'b01,  // use the result being written back
    FWD_MEM = 2'b10   // use the ALU result sitting in the memory stage
  } fwd_sel_e;

  localparam int unsigned REG_IDX_W = 5;

  // A producer can forward only if it writes a real register that matches.
  function automatic logic hits(input logic                 reg_write,
                                input logic [REG_IDX_W-1:0] rd,
                                input logic [REG_IDX_W-1:0] rs);
    return reg_write && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
//   Chooses where one source operand comes from. The memory stage holds the
//   younger result, so it wins over write-back. Register x0 never forwards.
// Ports:
//   Rs        in  5  source register index of the held instruction
//   RdM, RdW  in  5  destination indices in the memory / write-back stages
//   RegWriteM in  1  memory-stage writeback enable
//   RegWriteW in  1  write-back-stage writeback enable
//   Sel       out    forward select (FWD_REG / FWD_WB / FWD_MEM)
// ---------------------------------------------------------------------------
module forward_unit
  import ex_operand_stage_pkg::*;
(
  input  logic [REG_IDX_W-1:0] Rs,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  output fwd_sel_e             Sel
);

  always_comb begin
    Sel = FWD_REG;
    if (hits(RegWriteM, RdM, Rs)) begin
      Sel = FWD_MEM;
    end else if (hits(RegWriteW, RdW, Rs)) begin
      Sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//   One-entry decode->execute pipeline register with valid/ready handshake
//   and operand forwarding from the memory and write-back stages.
//   Forwarding is purely combinational on the held indices, so a stalled
//   instruction keeps picking up results that retire while it waits.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   InValid / InReady              decode-side handshake
//   RD1D, RD2D, ImmExtD            decoded operands and extended immediate
//   Rs1D, Rs2D, RdD                register indices
//   ALUSrcD, ALUControlD, RegWriteD decoded control
//   Flush                          drop the held entry (and any same-cycle input)
//   ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW  forwarding sources
//   OutValid / OutReady            execute-side handshake
//   SrcA, SrcB, WriteDataE         ALU operands and store data
//   ALUControlE, RdE, RegWriteE    registered control toward execute
// ---------------------------------------------------------------------------
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            ALUSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic            RegWriteD,

  input  logic            Flush,

  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdM,
  input  logic [4:0]      RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,

  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] WriteDataE,
  output logic [2:0]      ALUControlE,
  output logic [4:0]      RdE,
  output logic            RegWriteE
);

  // Held entry
  logic            valid_reg;
  logic [XLEN-1:0] rd1_reg;
  logic [XLEN-1:0] rd2_reg;
  logic [XLEN-1:0] imm_ext_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [4:0]      rd_reg;
  logic            alu_src_reg;
  alu_op_e         alu_control_reg;
  logic            reg_write_reg;

  logic            take;
  logic            valid_next;

  fwd_sel_e        sel_a;
  fwd_sel_e        sel_b;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign InReady  = !valid_reg || OutReady;
  assign OutValid = valid_reg;

  // Payload is loaded only for entries that survive; a flushed input transfer
  // is accepted (InReady is honoured) but never lands.
  assign take = InValid && InReady && !Flush;

  always_comb begin
    valid_next = valid_reg;
    if (Flush) begin
      valid_next = 1'b0;
    end else if (take) begin
      valid_next = 1'b1;
    end else if (valid_reg && OutReady) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_reg         <= '0;
      rd2_reg         <= '0;
      imm_ext_reg     <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      rd_reg          <= '0;
      alu_src_reg     <= 1'b0;
      alu_control_reg <= ALU_ADD;
      reg_write_reg   <= 1'b0;
    end else if (take) begin
      rd1_reg         <= RD1D;
      rd2_reg         <= RD2D;
      imm_ext_reg     <= ImmExtD;
      rs1_reg         <= Rs1D;
      rs2_reg         <= Rs2D;
      rd_reg          <= RdD;
      alu_src_reg     <= ALUSrcD;
      alu_control_reg <= alu_op_e'(ALUControlD);
      reg_write_reg   <= RegWriteD;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding
  // -------------------------------------------------------------------------
  forward_unit u_fwd_a (
    .Rs        (rs1_reg),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Sel       (sel_a)
  );

  forward_unit u_fwd_b (
    .Rs        (rs2_reg),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Sel       (sel_b)
  );

  always_comb begin
    fwd_a = rd1_reg;
    unique case (sel_a)
      FWD_MEM: fwd_a = ALUResultM;
      FWD_WB:  fwd_a = ResultW;
      default: fwd_a = rd1_reg;
    endcase
  end

  always_comb begin
    fwd_b = rd2_reg;
    unique case (sel_b)
      FWD_MEM: fwd_b = ALUResultM;
      FWD_WB:  fwd_b = ResultW;
      default: fwd_b = rd2_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign SrcA        = fwd_a;
  assign SrcB        = alu_src_reg ? imm_ext_reg : fwd_b;
  assign WriteDataE  = fwd_b;
  assign ALUControlE = alu_control_reg;
  assign RdE         = rd_reg;
  // A bubble must never write back, whatever stale control it holds.
  assign RegWriteE   = valid_reg && reg_write_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            InValid;
  logic            InReady;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            ALUSrcD;
  logic [2:0]      ALUControlD;
  logic            RegWriteD;
  logic            Flush;
  logic [XLEN-1:0] ALUResultM, ResultW;
  logic [4:0]      RdM, RdW;
  logic            RegWriteM, RegWriteW;
  logic            OutValid;
  logic            OutReady;
  logic [XLEN-1:0] SrcA, SrcB, WriteDataE;
  logic [2:0]      ALUControlE;
  logic [4:0]      RdE;
  logic            RegWriteE;

  int errors = 0;
  int checks = 0;

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .InValid(InValid), .InReady(InReady),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .RegWriteD(RegWriteD),
    .Flush(Flush),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .OutValid(OutValid), .OutReady(OutReady),
    .SrcA(SrcA), .SrcB(SrcB), .WriteDataE(WriteDataE),
    .ALUControlE(ALUControlE), .RdE(RdE), .RegWriteE(RegWriteE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alusrc;
    logic [2:0]  ctl;
    logic        regwrite;
    logic [31:0] alum, resw;
    logic [4:0]  rdm, rdw;
    logic        regwm, regww;
    logic [31:0] exp_a, exp_b, exp_wd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [31:0] rd1, input logic [31:0] rd2, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic rw);
    RD1D = rd1; RD2D = rd2; ImmExtD = '0;
    Rs1D = rs1; Rs2D = rs2; RdD = rd;
    ALUSrcD = 1'b0; ALUControlD = 3'b000; RegWriteD = rw;
  endtask

  task automatic clear_fwd();
    ALUResultM = '0; ResultW = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  initial begin
    //        rd1        rd2        imm         rs1 rs2 rd  src ctl    rw   alum       resw       rdm rdw wm   ww    expA       expB        expWD
    vecs[0] = '{32'd5,     32'd7,     32'd0,        5'd1, 5'd2, 5'd10, 1'b0, 3'b000, 1'b1, 32'h0,  32'h0,  5'd0, 5'd0, 1'b0, 1'b0, 32'd5,  32'd7,       32'd7};
    vecs[1] = '{32'h11,    32'h22,    32'd0,        5'd3, 5'd4, 5'd11, 1'b0, 3'b001, 1'b0, 32'h10, 32'h20, 5'd3, 5'd3, 1'b1, 1'b1, 32'h10, 32'h22,      32'h22};
    vecs[2] = '{32'h11,    32'h22,    32'd0,        5'd3, 5'd4, 5'd12, 1'b0, 3'b010, 1'b1, 32'h10, 32'h20, 5'd3, 5'd3, 1'b0, 1'b1, 32'h20, 32'h22,      32'h22};
    vecs[3] = '{32'h33,    32'd0,     32'd0,        5'd0, 5'd0, 5'd13, 1'b0, 3'b011, 1'b1, 32'hFF, 32'hAB, 5'd0, 5'd0, 1'b1, 1'b1, 32'h33, 32'd0,       32'd0};
    vecs[4] = '{32'd1,     32'd2,     32'hFFFFFFFC, 5'd7, 5'd6, 5'd14, 1'b1, 3'b100, 1'b1, 32'd9,  32'h0,  5'd6, 5'd0, 1'b1, 1'b0, 32'd1,  32'hFFFFFFFC, 32'd9};
    vecs[5] = '{32'd3,     32'd4,     32'd0,        5'd9, 5'd8, 5'd15, 1'b0, 3'b101, 1'b0, 32'h77, 32'h55, 5'd9, 5'd8, 1'b1, 1'b1, 32'h77, 32'h55,      32'h55};
    vecs[6] = '{32'hA0,    32'hB0,    32'd0,        5'd5, 5'd6, 5'd31, 1'b0, 3'b000, 1'b1, 32'h66, 32'h99, 5'd5, 5'd6, 1'b0, 1'b0, 32'hA0, 32'hB0,      32'hB0};

    rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1; Flush = 1'b0;
    drive_entry('0, '0, '0, '0, '0, 1'b0);
    clear_fwd();
    #2;
    // During reset
    check("reset_outvalid", {31'd0, OutValid}, 32'd0);
    check("reset_inready",  {31'd0, InReady},  32'd1);
    check("reset_srca",     SrcA, 32'd0);
    check("reset_srcb",     SrcB, 32'd0);
    check("reset_wd",       WriteDataE, 32'd0);
    check("reset_ctl",      {29'd0, ALUControlE}, 32'd0);
    check("reset_rde",      {27'd0, RdE}, 32'd0);
    check("reset_rwe",      {31'd0, RegWriteE}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_outvalid", {31'd0, OutValid}, 32'd0);

    // Table-driven captures, each entry consumed the next cycle
    for (int i = 0; i < 7; i++) begin
      RD1D = vecs[i].rd1; RD2D = vecs[i].rd2; ImmExtD = vecs[i].imm;
      Rs1D = vecs[i].rs1; Rs2D = vecs[i].rs2; RdD = vecs[i].rd;
      ALUSrcD = vecs[i].alusrc; ALUControlD = vecs[i].ctl; RegWriteD = vecs[i].regwrite;
      ALUResultM = vecs[i].alum; ResultW = vecs[i].resw;
      RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].regwm; RegWriteW = vecs[i].regww;
      InValid = 1'b1; OutReady = 1'b1;
      step();
      check($sformatf("v%0d_outvalid", i), {31'd0, OutValid}, 32'd1);
      check($sformatf("v%0d_srca", i), SrcA, vecs[i].exp_a);
      check($sformatf("v%0d_srcb", i), SrcB, vecs[i].exp_b);
      check($sformatf("v%0d_wd", i), WriteDataE, vecs[i].exp_wd);
      check($sformatf("v%0d_ctl", i), {29'd0, ALUControlE}, {29'd0, vecs[i].ctl});
      check($sformatf("v%0d_rde", i), {27'd0, RdE}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d_rwe", i), {31'd0, RegWriteE}, {31'd0, vecs[i].regwrite});
      $display("vec %0d: SrcA=%h SrcB=%h WD=%h", i, SrcA, SrcB, WriteDataE);
    end

    // Drain: no new input, entry consumed
    InValid = 1'b0;
    clear_fwd();
    step();
    check("drain_outvalid", {31'd0, OutValid}, 32'd0);
    check("drain_rwe", {31'd0, RegWriteE}, 32'd0);
    $display("drain: OutValid=%0b", OutValid);

    // Stall: entry held while OutReady=0, forwarding keeps tracking
    drive_entry(32'h100, 32'h101, 5'd3, 5'd4, 5'd20, 1'b1);
    InValid = 1'b1; OutReady = 1'b1;
    step();
    drive_entry(32'h200, 32'h201, 5'd3, 5'd4, 5'd21, 1'b1);
    OutReady = 1'b0;
    #1;
    check("stall_inready0", {31'd0, InReady}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_outvalid", c), {31'd0, OutValid}, 32'd1);
      check($sformatf("stall%0d_inready", c), {31'd0, InReady}, 32'd0);
      check($sformatf("stall%0d_srca", c), SrcA, 32'h100);
      check($sformatf("stall%0d_rde", c), {27'd0, RdE}, 32'd20);
      $display("stall cycle %0d: SrcA=%h RdE=%0d", c, SrcA, RdE);
    end
    // A result retiring during the stall must reach the held operand
    ALUResultM = 32'hBEEF; RdM = 5'd3; RegWriteM = 1'b1;
    #1;
    check("stall_fwd_srca", SrcA, 32'hBEEF);
    clear_fwd();
    OutReady = 1'b1;
    #1;
    check("stall_release_inready", {31'd0, InReady}, 32'd1);
    step();
    check("stall_new_srca", SrcA, 32'h200);
    check("stall_new_rde", {27'd0, RdE}, 32'd21);
    $display("stall release: SrcA=%h RdE=%0d", SrcA, RdE);

    // Flush with a same-cycle input transfer
    drive_entry(32'h300, 32'h301, 5'd1, 5'd2, 5'd22, 1'b1);
    InValid = 1'b1; Flush = 1'b1; OutReady = 1'b1;
    #1;
    check("flush_inready", {31'd0, InReady}, 32'd1);
    step();
    check("flush_outvalid", {31'd0, OutValid}, 32'd0);
    check("flush_rwe", {31'd0, RegWriteE}, 32'd0);
    $display("flush: OutValid=%0b RegWriteE=%0b", OutValid, RegWriteE);
    Flush = 1'b0;

    // Async reset while an entry is held
    drive_entry(32'h400, 32'h401, 5'd1, 5'd2, 5'd23, 1'b1);
    InValid = 1'b1; OutReady = 1'b0;
    step();
    check("prerst_outvalid", {31'd0, OutValid}, 32'd1);
    InValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("async_rst_srca", SrcA, 32'd0);
    check("async_rst_rde", {27'd0, RdE}, 32'd0);
    check("async_rst_rwe", {31'd0, RegWriteE}, 32'd0);
    check("async_rst_inready", {31'd0, InReady}, 32'd1);
    $display("async reset: OutValid=%0b SrcA=%h", OutValid, SrcA);
    step();
    rst_n = 1'b1;
    step();
    check("after_rst_outvalid", {31'd0, OutValid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low; the block uses one clock.
REQ-004 SHALL have port InValid / InReady  input / output  1 / 1  decode-side handshake.
REQ-005 SHALL have port RD1D, RD2D, ImmExtD  input  XLEN each  decoded register operands and extended immediate.
REQ-006 SHALL have port Rs1D, Rs2D, RdD  input  5 each  source and destination register indices.
REQ-007 SHALL have port ALUSrcD  input  1  1 selects ImmExt for SrcB; port ALUControlD  input  3  ALU opcode.
REQ-008 SHALL have port RegWriteD  input  1  destination writeback enable.
REQ-009 SHALL have port Flush  input  1  discard the held entry.
REQ-010 SHALL have ports ALUResultM, ResultW  input  XLEN; RdM, RdW  input  5; RegWriteM, RegWriteW  input  1  forwarding sources.
REQ-011 SHALL have port OutValid / OutReady  output / input  1 / 1  execute-side handshake.
REQ-012 SHALL have ports SrcA, SrcB, WriteDataE  output  XLEN  ALU operands and store data.
REQ-013 SHALL have ports ALUControlE  output  3; RdE  output  5; RegWriteE  output  1  registered control.

Function
REQ-014 SHALL hold one entry: valid flag plus registered RD1, RD2, ImmExt, Rs1, Rs2, Rd, ALUSrc, ALUControl, RegWrite.
REQ-015 SHALL drive InReady = !valid || OutReady, combinationally.
REQ-016 SHALL capture the full payload and set valid on the clock edge when InValid && InReady && !Flush; latency is 1 cycle.
REQ-017 SHALL clear valid on the edge when OutValid && OutReady and no new entry is captured.
REQ-018 SHALL give Flush priority: valid=0 next cycle; a same-cycle input transfer is accepted and dropped; payload registers are not cleared.
REQ-019 SHALL hold the payload unchanged while valid && !OutReady (stall), with InReady=0.
REQ-020 SHALL drive OutValid = valid; RegWriteE = valid && RegWrite_q, so a bubble never writes.
REQ-021 SHALL forward A from ALUResultM if RegWriteM && RdM!=0 && RdM==Rs1_q; else from ResultW if RegWriteW && RdW!=0 && RdW==Rs1_q; else RD1_q (MEM beats WB).
REQ-022 SHALL forward B by the same rules using Rs2_q; WriteDataE = forwarded B.
REQ-023 SHALL drive SrcA = forwarded A; SrcB = ALUSrc_q ? ImmExt_q : forwarded B.
REQ-024 SHALL evaluate forwarding combinationally every cycle, including stall cycles, so stalled operands track newer results.
REQ-025 SHALL never forward for index x0, even with RegWrite set.
REQ-026 SHALL pass ALUControl_q unchanged: 000 add, 001 sub, 010 and, 011 or, 100 pass B, 101 slt.

Reset
REQ-027 SHALL, on rst_n low, immediately clear valid and all payload registers to 0.
REQ-028 SHALL, during and after reset until first capture, output OutValid=0, InReady=1, SrcA=SrcB=WriteDataE=0, ALUControlE=000, RdE=0, RegWriteE=0.
REQ-029 SHALL, on reset assertion mid-transfer, lose the held entry with no partial output.

Structure
REQ-030 SHALL place in a shared package: ALU opcode enum (3-bit values above) and a 2-bit forward-select enum (REG, WB, MEM).
REQ-031 SHALL implement A and B forwarding with two instances of a sub-module forward_unit (inputs Rs, RdM, RdW, RegWriteM, RegWriteW; output forward-select).

Verification
REQ-032 SHALL cover reset and capture: RD1D=5, RD2D=7, ALUSrcD=0, ALUControlD=000, InValid=1, OutReady=1 -> next cycle OutValid=1, SrcA=5, SrcB=7.
REQ-033 SHALL cover forward priority: Rs1_q=3, RdM=3, RdW=3, both RegWrite=1, ALUResultM=0x10, ResultW=0x20 -> SrcA=0x10; RegWriteM=0 -> SrcA=0x20.
REQ-034 SHALL cover x0: Rs2_q=0, RdM=0, RegWriteM=1, ALUResultM=0xFF, RD2_q=0 -> WriteDataE=0.
REQ-035 SHALL cover immediate select: ALUSrc_q=1, ImmExt_q=0xFFFFFFFC, Rs2 forwarded 9 -> SrcB=0xFFFFFFFC, WriteDataE=9.
REQ-036 SHALL cover stall: valid held, OutReady=0 three cycles, InValid=1 -> InReady=0, payload stable; OutReady=1 -> new entry captured next edge.
REQ-037 SHALL cover flush: Flush=1 with InValid=1, InReady=1 -> next cycle OutValid=0, RegWriteE=0.
